// File: rtl/ad_line_packer.sv
// Frames each AD video line as {SYNC_WORD, line index, samples..., tail} into a
// 17-bit FIFO (16 data + last) and streams the packets out on a valid/ready port.
module ad_line_packer #(
    parameter int unsigned FIFO_AW   = 10,
    parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vsync_redge_i,
    input  logic        hsync_redge_i,
    input  logic        hsync_fedge_i,
    input  logic        sample_wena_i,
    input  logic [11:0] sample_i,
    output logic [15:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_last_o,
    output logic        overflow_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] line_idx_o
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_W = DEPTH[FIFO_AW:0];

    typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StData, StTail, StSkip} state_e;

    state_e             r_state, w_state_nxt;
    logic [16:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]   r_fcnt;
    logic [16:0]        r_out;
    logic               r_valid;
    logic               r_ovf, r_pend, r_vs_pend, r_drop;
    logic [14:0]        r_cnt;
    logic [15:0]        r_line_idx, r_frame;

    logic               w_ovf_nxt, w_pend_nxt, w_vs_pend_nxt, w_drop_nxt;
    logic [14:0]        w_cnt_nxt;
    logic [15:0]        w_idx_nxt;
    logic               w_wr_en, w_rd_en, w_room, w_start;
    logic [16:0]        w_wr_data;
    logic [31:0]        w_free;

    // Free space counts the output register too, so the whole packet path holds DEPTH words.
    assign w_free  = DEPTH - 32'(r_fcnt) - 32'(r_valid);
    assign w_room  = w_free >= 32'd4;
    assign w_start = r_pend | hsync_redge_i;
    assign w_rd_en = (r_fcnt != '0) && (!r_valid || out_ready_i);

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en       = 1'b0;
        w_wr_data     = '0;
        w_ovf_nxt     = r_ovf;
        w_pend_nxt    = r_pend;
        w_vs_pend_nxt = r_vs_pend;
        w_drop_nxt    = r_drop;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_line_idx;

        if (vsync_redge_i) begin
            if (r_state == StIdle || r_state == StSkip) w_idx_nxt = '0;
            else w_vs_pend_nxt = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (hsync_redge_i) begin
                    if (w_room) begin
                        w_state_nxt = StHdr0;
                    end else begin
                        w_state_nxt = StSkip;
                        w_ovf_nxt   = 1'b1;
                    end
                end
            end
            StHdr0: begin
                w_wr_en     = 1'b1;
                w_wr_data   = {1'b0, SYNC_WORD};
                w_state_nxt = StHdr1;
            end
            StHdr1: begin
                w_wr_en     = 1'b1;
                w_wr_data   = {1'b0, r_line_idx};
                w_cnt_nxt   = '0;
                w_drop_nxt  = 1'b0;
                w_state_nxt = StData;
            end
            StData: begin
                if (sample_wena_i) begin
                    // The last free slot is reserved for the tail word.
                    if (w_free > 32'd1) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = {5'b0, sample_i};
                        if (r_cnt != 15'h7FFF) w_cnt_nxt = r_cnt + 15'd1;
                    end else begin
                        w_drop_nxt = 1'b1;
                        w_ovf_nxt  = 1'b1;
                    end
                end
                if (hsync_redge_i) w_pend_nxt = 1'b1;
                if (hsync_fedge_i || hsync_redge_i) w_state_nxt = StTail;
            end
            StTail: begin
                w_wr_en       = 1'b1;
                w_wr_data     = {1'b1, r_drop, r_cnt};
                w_idx_nxt     = (r_vs_pend || vsync_redge_i) ? 16'd0 : r_line_idx + 16'd1;
                w_vs_pend_nxt = 1'b0;
                w_pend_nxt    = 1'b0;
                if (!w_start) begin
                    w_state_nxt = StIdle;
                end else if (w_room) begin
                    w_state_nxt = StHdr0;
                end else begin
                    w_state_nxt = StSkip;
                    w_ovf_nxt   = 1'b1;
                end
            end
            StSkip: begin
                if (hsync_fedge_i) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_ovf      <= 1'b0;
            r_pend     <= 1'b0;
            r_vs_pend  <= 1'b0;
            r_drop     <= 1'b0;
            r_cnt      <= '0;
            r_line_idx <= '0;
            r_frame    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ovf      <= w_ovf_nxt;
            r_pend     <= w_pend_nxt;
            r_vs_pend  <= w_vs_pend_nxt;
            r_drop     <= w_drop_nxt;
            r_cnt      <= w_cnt_nxt;
            r_line_idx <= w_idx_nxt;
            if (vsync_redge_i) r_frame <= r_frame + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wptr] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + 1'b1;
            if (w_rd_en) r_rptr <= r_rptr + 1'b1;
            if (w_wr_en && !w_rd_en) r_fcnt <= r_fcnt + 1'b1;
            else if (!w_wr_en && w_rd_en) r_fcnt <= r_fcnt - 1'b1;
        end
    end

    // Output register refills in the same cycle it is consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (w_rd_en) begin
            r_out   <= r_mem[r_rptr];
            r_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_wr_en && r_fcnt == DEPTH_W));

    assign out_data_o  = r_out[15:0];
    assign out_last_o  = r_out[16];
    assign out_valid_o = r_valid;
    assign overflow_o  = r_ovf;
    assign frame_cnt_o = r_frame;
    assign line_idx_o  = r_line_idx;

endmodule

// File: tb/tb_ad_line_packer.sv
// Bench for ad_line_packer: table-driven lines, hand-written corner sequences and
// randomized lines scored against a packet-level model of the expected stream.
module tb_ad_line_packer;
    localparam logic [3:0] C_VS = 4'b1000;
    localparam logic [3:0] C_HR = 4'b0100;
    localparam logic [3:0] C_HF = 4'b0010;
    localparam logic [3:0] C_WE = 4'b0001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vs, hr, hf, we, rdy;
    logic [11:0] smp;
    logic [15:0] a_data, a_frame, a_idx, b_data, b_frame, b_idx;
    logic        a_valid, a_last, a_ovf, b_valid, b_last, b_ovf;

    int          n_checks, n_fail, rdy_mode;
    logic [16:0] got_a[$], got_b[$], exp_q[$];
    logic [15:0] m_idx, m_frame, f0;
    logic        a_hold_v;
    logic [16:0] a_hold;

    typedef struct {
        int          nsamp;
        int          rmode;
        bit          vs_before;
        bit          fedge_last;
        logic [15:0] exp_idx;
        logic [15:0] exp_tail;
        logic [15:0] exp_next;
        logic [15:0] exp_frame;
    } line_vec_t;
    line_vec_t tab[5];

    always #5 clk = ~clk;

    ad_line_packer u_dut_a (
        .clk(clk), .reset_n(reset_n), .vsync_redge_i(vs), .hsync_redge_i(hr),
        .hsync_fedge_i(hf), .sample_wena_i(we), .sample_i(smp), .out_data_o(a_data),
        .out_valid_o(a_valid), .out_ready_i(rdy), .out_last_o(a_last), .overflow_o(a_ovf),
        .frame_cnt_o(a_frame), .line_idx_o(a_idx)
    );

    ad_line_packer #(.FIFO_AW(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .vsync_redge_i(vs), .hsync_redge_i(hr),
        .hsync_fedge_i(hf), .sample_wena_i(we), .sample_i(smp), .out_data_o(b_data),
        .out_valid_o(b_valid), .out_ready_i(rdy), .out_last_o(b_last), .overflow_o(b_ovf),
        .frame_cnt_o(b_frame), .line_idx_o(b_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: rdy = 1'b1;
            1: rdy = ~rdy;
            2: rdy = 1'b0;
            default: rdy = 1'($urandom);
        endcase
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [11:0] s);
        {vs, hr, hf, we} = ctl;
        smp = s;
        step();
        {vs, hr, hf, we} = '0;
    endtask

    // Drives one complete line from IDLE and queues the words it must produce.
    task automatic run_line(input int n, input bit vs_mid, input bit fw, input bit gaps,
                            input logic [15:0] eidx, input logic [15:0] etail);
        logic [11:0] s;
        drive(C_HR, '0);
        step();
        step();
        exp_q.push_back({1'b0, 16'hEB90});
        exp_q.push_back({1'b0, eidx});
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            s = 12'($urandom);
            exp_q.push_back({5'b0, s});
            drive({vs_mid && (k == n / 2), 1'b0, fw && (k == n - 1), 1'b1}, s);
        end
        if (!(fw && n > 0)) drive({vs_mid && (n == 0), 2'b01, 1'b0}, '0);
        exp_q.push_back({1'b1, etail});
        step();
        step();
        m_idx = vs_mid ? 16'd0 : eidx + 16'd1;
        if (vs_mid) m_frame = m_frame + 16'd1;
    endtask

    task automatic drain(input bit use_b, input string name);
        logic [16:0] g, e;
        int t;
        t = 0;
        while ((use_b ? got_b.size() : got_a.size()) < exp_q.size() && t < 3000) begin
            step();
            t++;
        end
        repeat (6) step();
        chk({name, "_count"}, 32'(use_b ? got_b.size() : got_a.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && (use_b ? got_b.size() : got_a.size()) > 0) begin
            e = exp_q.pop_front();
            if (use_b) g = got_b.pop_front();
            else g = got_a.pop_front();
            chk(name, 32'(g), 32'(e));
        end
        exp_q.delete();
        got_a.delete();
        got_b.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {vs, hr, hf, we} = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        got_a.delete();
        got_b.delete();
        exp_q.delete();
        m_idx = '0;
        m_frame = '0;
        step();
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            a_hold_v = 1'b0;
        end else begin
            if (a_hold_v) chk("stall_hold", 32'({a_valid, a_last, a_data}), 32'({1'b1, a_hold}));
            if (a_valid && rdy) got_a.push_back({a_last, a_data});
            if (b_valid && rdy) got_b.push_back({b_last, b_data});
            a_hold_v = a_valid && !rdy;
            a_hold   = {a_last, a_data};
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        {vs, hr, hf, we} = '0;
        smp      = '0;
        rdy      = 1'b0;
        rdy_mode = 0;
        m_idx    = '0;
        m_frame  = '0;
        a_hold_v = 1'b0;
        a_hold   = '0;
        tab[0] = '{5, 1, 1'b0, 1'b0, 16'd1, 16'h0005, 16'd2, 16'd1};
        tab[1] = '{3, 3, 1'b0, 1'b1, 16'd2, 16'h0003, 16'd3, 16'd1};
        tab[2] = '{0, 1, 1'b0, 1'b0, 16'd3, 16'h0000, 16'd4, 16'd1};
        tab[3] = '{8, 3, 1'b1, 1'b0, 16'd0, 16'h0008, 16'd1, 16'd2};
        tab[4] = '{1, 1, 1'b0, 1'b1, 16'd1, 16'h0001, 16'd2, 16'd2};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_last", 32'(a_last), 32'd0);
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        chk("rst_frame", 32'(a_frame), 32'd0);
        chk("rst_idx", 32'(a_idx), 32'd0);
        reset_n = 1'b1;
        step();

        // Basic line with header and sample latency checks.
        drive(C_VS, '0);
        m_frame = 16'd1;
        chk("vs_frame", 32'(a_frame), 32'd1);
        drive(C_HR, '0);
        step();
        chk("hdr_early", 32'(a_valid), 32'd0);
        step();
        chk("hdr_t3", 32'({a_valid, a_data}), 32'({1'b1, 16'hEB90}));
        exp_q.push_back({1'b0, 16'hEB90});
        exp_q.push_back({1'b0, 16'h0000});
        for (int k = 1; k <= 5; k++) begin
            drive(C_WE, 12'(k));
            exp_q.push_back(17'(k));
            if (k == 2) chk("smp_latency", 32'({a_valid, a_data}), 32'({1'b1, 16'h0001}));
        end
        drive(C_HF, '0);
        exp_q.push_back({1'b1, 16'h0005});
        step();
        chk("basic_idx", 32'(a_idx), 32'd1);
        drain(1'b0, "basic");
        m_idx = 16'd1;

        for (int i = 0; i < 5; i++) begin
            rdy_mode = tab[i].rmode;
            if (tab[i].vs_before) begin
                drive(C_VS, '0);
                m_frame = m_frame + 16'd1;
                m_idx = '0;
            end
            run_line(tab[i].nsamp, 1'b0, tab[i].fedge_last, 1'b1, tab[i].exp_idx,
                     tab[i].exp_tail);
            chk("tab_idx", 32'(a_idx), 32'(tab[i].exp_next));
            chk("tab_frame", 32'(a_frame), 32'(tab[i].exp_frame));
            drain(1'b0, "tab_stream");
            chk("tab_ovf", 32'(a_ovf), 32'd0);
        end

        // Missing fedge, then a new line started during TAIL.
        rdy_mode = 3;
        drive(C_HR, '0);
        step();
        step();
        exp_q.push_back({1'b0, 16'hEB90});
        exp_q.push_back({1'b0, m_idx});
        for (int k = 1; k <= 3; k++) begin
            drive(C_WE, 12'(k));
            exp_q.push_back(17'(k));
        end
        drive(C_HR, '0);
        exp_q.push_back({1'b1, 16'h0003});
        m_idx = m_idx + 16'd1;
        repeat (3) step();
        exp_q.push_back({1'b0, 16'hEB90});
        exp_q.push_back({1'b0, m_idx});
        drive(C_WE, 12'h0A1);
        drive(C_WE | C_HF, 12'h0A2);
        exp_q.push_back(17'h0A1);
        exp_q.push_back(17'h0A2);
        drive(C_HR, '0);
        exp_q.push_back({1'b1, 16'h0002});
        m_idx = m_idx + 16'd1;
        step();
        step();
        exp_q.push_back({1'b0, 16'hEB90});
        exp_q.push_back({1'b0, m_idx});
        drive(C_WE | C_HF, 12'h0B1);
        exp_q.push_back(17'h0B1);
        exp_q.push_back({1'b1, 16'h0001});
        m_idx = m_idx + 16'd1;
        step();
        step();
        chk("mf_idx", 32'(a_idx), 32'(m_idx));
        drain(1'b0, "missing_fedge");

        // Frame wrap: vsync arrives in the middle of the third line of a frame.
        rdy_mode = 0;
        drive(C_VS, '0);
        m_frame = m_frame + 16'd1;
        m_idx = '0;
        run_line(2, 1'b0, 1'b0, 1'b0, m_idx, 16'h0002);
        run_line(2, 1'b0, 1'b1, 1'b0, m_idx, 16'h0002);
        f0 = a_frame;
        run_line(4, 1'b1, 1'b0, 1'b0, 16'd2, 16'h0004);
        chk("wrap_frame", 32'(a_frame), 32'(f0 + 16'd1));
        chk("wrap_idx", 32'(a_idx), 32'd0);
        run_line(1, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0001);
        drain(1'b0, "frame_wrap");

        // Asynchronous reset in the middle of a line with words queued.
        rdy_mode = 2;
        drive(C_HR, '0);
        step();
        step();
        for (int k = 1; k <= 4; k++) drive(C_WE, 12'(k));
        chk("pre_rst_valid", 32'(a_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(a_valid), 32'd0);
        chk("arst_data", 32'(a_data), 32'd0);
        chk("arst_frame", 32'(a_frame), 32'd0);
        chk("arst_idx", 32'(a_idx), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        got_a.delete();
        got_b.delete();
        exp_q.delete();
        m_idx = '0;
        m_frame = '0;
        rdy_mode = 0;
        step();
        run_line(3, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0003);
        chk("post_rst_idx", 32'(a_idx), 32'd1);
        drain(1'b0, "post_reset");

        // Overflow on the small-FIFO instance, with the consumer stalled.
        rdy_mode = 2;
        do_reset();
        drive(C_HR, '0);
        step();
        step();
        for (int k = 1; k <= 10; k++) drive(C_WE, 12'(k));
        drive(C_HF, '0);
        step();
        chk("ovf_flag", 32'(b_ovf), 32'd1);
        chk("ovf_idx", 32'(b_idx), 32'd1);
        drive(C_HR, '0);
        step();
        drive(C_WE, 12'h055);
        drive(C_WE, 12'h066);
        drive(C_HF, '0);
        step();
        chk("skip_idx", 32'(b_idx), 32'd1);
        chk("skip_ovf", 32'(b_ovf), 32'd1);
        exp_q.push_back({1'b0, 16'hEB90});
        exp_q.push_back({1'b0, 16'h0000});
        for (int k = 1; k <= 5; k++) exp_q.push_back(17'(k));
        exp_q.push_back({1'b1, 16'h8005});
        rdy_mode = 0;
        drain(1'b1, "ovf_stream");

        // Randomized lines against the packet model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int n;
            case ($urandom_range(0, 2))
                0: rdy_mode = 0;
                1: rdy_mode = 1;
                default: rdy_mode = 3;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                drive(C_VS, '0);
                m_frame = m_frame + 16'd1;
                m_idx = '0;
            end
            n = int'($urandom_range(0, 20));
            run_line(n, $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom), m_idx,
                     {1'b0, 15'(n)});
            chk("rnd_idx", 32'(a_idx), 32'(m_idx));
            chk("rnd_frame", 32'(a_frame), 32'(m_frame));
        end
        rdy_mode = 3;
        drain(1'b0, "rnd_stream");
        chk("rnd_ovf", 32'(a_ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
